// File: rtl/vga_tile_scheduler.sv
// rtl/vga_tile_scheduler.sv - per-tile-row sprite scheduler building a double-buffered tile-type line
// The back buffer is filled for the next tile row while the pixel path reads the front buffer.
module vga_tile_scheduler #(
    parameter int max_len         = 31,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 5,
    parameter int width           = 32,
    parameter int height          = 24,
    parameter int tile            = 20
) (
    input  logic                       vga_clk,
    input  logic                       vga_rst,
    input  logic [max_len*num_len-1:0] snake1,
    input  logic [max_len*num_len-1:0] snake2,
    input  logic [max_len_bit_len-1:0] score1,
    input  logic [max_len_bit_len-1:0] score2,
    input  logic [num_len-1:0]         food1,
    input  logic [num_len-1:0]         food2,
    input  logic [9:0]                 row_addr,
    input  logic [9:0]                 col_addr,
    output logic [2:0]                 tile_type,
    output logic [4:0]                 tile_px_row,
    output logic [4:0]                 tile_px_col,
    output logic                       busy,
    output logic                       overrun
);
    localparam int WB = $clog2(width);
    localparam int TW = num_len - WB;
    localparam int CW = (WB > $clog2(max_len)) ? WB : $clog2(max_len);
    localparam logic [9:0] VIS_ROWS = 10'(tile * height);
    localparam logic [9:0] VIS_COLS = 10'(tile * width);
    localparam logic [num_len-1:0] P_NONE  = '1;
    localparam logic [num_len-1:0] P_LIMIT = num_len'(width * height);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FOOD, S_S2, S_S1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tgt_q, tgt_d;
    logic            overrun_q, overrun_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_cond_q, scan_cond_q;
    logic [2:0]      buf_a_q [width];
    logic [2:0]      buf_b_q [width];
    logic [2:0]      tile_type_q, tile_type_d;
    logic [4:0]      px_row_q, px_row_d, px_col_q, px_col_d;

    logic            swap_cond, scan_cond, swap_fire, scan_fire;
    logic [9:0]      row_tile;
    logic [TW-1:0]   scan_tgt;
    logic [num_len-1:0] item_p;
    logic [2:0]      item_type;
    logic            item_ok, wr_en;
    logic [WB-1:0]   wr_idx, rd_idx;
    logic [2:0]      wr_data;

    // Edge-detected swap/scan triggers derived from the raster position
    always_comb begin
        row_tile    = 10'(row_addr / tile);
        swap_cond   = (row_addr < VIS_ROWS) && (10'(row_addr % tile) == 10'd0) && (col_addr == 10'd0);
        scan_cond   = (swap_cond && (row_tile < 10'(height - 1)))
                    || ((row_addr == VIS_ROWS) && (col_addr == 10'd0));
        scan_tgt    = swap_cond ? TW'(row_tile + 10'd1) : '0;
        swap_fire   = swap_cond && !swap_cond_q;
        scan_fire   = scan_cond && !scan_cond_q;
        front_sel_d = front_sel_q ^ swap_fire;
    end

    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            overrun_q   <= 1'b0;
            front_sel_q <= 1'b0;
            swap_cond_q <= 1'b0;
            scan_cond_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            overrun_q   <= overrun_d;
            front_sel_q <= front_sel_d;
            swap_cond_q <= swap_cond;
            scan_cond_q <= scan_cond;
        end
    end

    // A new trigger always restarts at CLEAR, aborting any scan in flight
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        overrun_d = overrun_q;
        if (scan_fire) begin
            if (state_q != S_IDLE) overrun_d = 1'b1;
            state_d = S_CLEAR;
            cnt_d   = '0;
            tgt_d   = scan_tgt;
        end else begin
            case (state_q)
                S_CLEAR: if (cnt_q == CW'(width - 1)) begin
                             state_d = S_FOOD;
                             cnt_d   = '0;
                         end else cnt_d = cnt_q + 1'b1;
                S_FOOD:  if (cnt_q == CW'(1)) begin
                             state_d = S_S2;
                             cnt_d   = CW'(max_len - 1);
                         end else cnt_d = cnt_q + 1'b1;
                S_S2:    if (cnt_q == '0) begin
                             state_d = S_S1;
                             cnt_d   = CW'(max_len - 1);
                         end else cnt_d = cnt_q - 1'b1;
                S_S1:    if (cnt_q == '0) state_d = S_IDLE;
                         else cnt_d = cnt_q - 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Writes go lowest priority first so later items overwrite earlier ones
    always_comb begin
        item_p    = P_NONE;
        item_type = 3'd0;
        item_ok   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = cnt_q[WB-1:0];
        wr_data   = 3'd0;
        case (state_q)
            S_FOOD: begin
                item_p    = cnt_q[0] ? food2 : food1;
                item_type = cnt_q[0] ? 3'd2 : 3'd1;
                item_ok   = 1'b1;
            end
            S_S2: begin
                item_p    = snake2[int'(cnt_q) * num_len +: num_len];
                item_type = (cnt_q == '0) ? 3'd6 : 3'd5;
                item_ok   = int'(cnt_q) < int'(score2);
            end
            S_S1: begin
                item_p    = snake1[int'(cnt_q) * num_len +: num_len];
                item_type = (cnt_q == '0) ? 3'd4 : 3'd3;
                item_ok   = int'(cnt_q) < int'(score1);
            end
            default: ;
        endcase
        if (state_q == S_CLEAR) begin
            wr_en = 1'b1;
        end else if (item_ok && (item_p != P_NONE) && (item_p < P_LIMIT)
                     && (item_p[num_len-1:WB] == tgt_q)) begin
            wr_en   = 1'b1;
            wr_idx  = item_p[WB-1:0];
            wr_data = item_type;
        end
    end

    // Back buffer is always the one not selected by the post-swap front select
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            for (int k = 0; k < width; k++) begin
                buf_a_q[k] <= 3'd0;
                buf_b_q[k] <= 3'd0;
            end
        end else if (wr_en) begin
            if (front_sel_d) buf_a_q[wr_idx] <= wr_data;
            else             buf_b_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_idx      = WB'(col_addr / tile);
        tile_type_d = 3'd0;
        px_row_d    = 5'd0;
        px_col_d    = 5'd0;
        if ((row_addr < VIS_ROWS) && (col_addr < VIS_COLS)) begin
            tile_type_d = front_sel_d ? buf_b_q[rd_idx] : buf_a_q[rd_idx];
            px_row_d    = 5'(row_addr % tile);
            px_col_d    = 5'(col_addr % tile);
        end
    end

    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            tile_type_q <= 3'd0;
            px_row_q    <= 5'd0;
            px_col_q    <= 5'd0;
        end else begin
            tile_type_q <= tile_type_d;
            px_row_q    <= px_row_d;
            px_col_q    <= px_col_d;
        end
    end

    assign tile_type   = tile_type_q;
    assign tile_px_row = px_row_q;
    assign tile_px_col = px_col_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
endmodule
